adder_share_arb: RTL and testbench

- Shares one instance of the 64-bit hierarchical add-one carry-select adder (a1csah64bits) between NREQ requesters.
- Each requester submits a multi-word addition as a sequence of 64-bit beats, least significant word first. Carry is chained across beats through a register.
- A round-robin arbiter locks onto one requester for a whole transaction. Results leave through one registered valid/ready output stage.

---
 rtl/adder_share_arb.sv | 167 ++++++++++++++++
 tb/tb_adder_share_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one carry-select adder across multi-beat requesters
module adder_share_arb #(
  parameter int N        = 64,
  parameter int NREQ     = 2,
  parameter int MAXBEATS = 4,
  parameter int IDW      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic [NREQ-1:0]     req_cin,
  input  logic [NREQ-1:0]     req_last,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N-1:0]        res_s,
  output logic                res_cout,
  output logic [IDW-1:0]      res_id,
  output logic                res_last,
  output logic                res_trunc
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [IDW-1:0] owner, owner_n, rr_ptr, rr_n, pick_lo, pick_hi;
  logic found_hi;
  logic [4:0] beat_cnt, beat_n;
  logic carry_reg, carry_n;
  logic [N-1:0] op_a, op_b, sum;
  logic own_valid, own_cin, own_last, cin, cout, accept, out_free, at_max, fin;
  logic unused_gen, unused_prop;
  // owner operand mux, handshake and carry selection
  always_comb begin
    op_a = '0;
    op_b = '0;
    own_valid = 1'b0;
    own_cin = 1'b0;
    own_last = 1'b0;
    req_ready = '0;
    out_free = ~res_valid | res_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        op_a = req_a[i*N +: N];
        op_b = req_b[i*N +: N];
        own_valid = req_valid[i];
        own_cin = req_cin[i];
        own_last = req_last[i];
        req_ready[i] = ~rst & (state == LOCKED) & out_free;
      end
    end
    accept = (state == LOCKED) & own_valid & out_free;
    cin = (beat_cnt == 5'd0) ? own_cin : carry_reg;
    at_max = beat_cnt == 5'(MAXBEATS-1);
    fin = own_last | at_max;
  end
  // round-robin pick: lowest valid index at or above rr_ptr, else lowest overall
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    found_hi = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) pick_lo = IDW'(i);
      if (req_valid[i] && IDW'(i) >= rr_ptr) begin
        pick_hi = IDW'(i);
        found_hi = 1'b1;
      end
    end
  end
  // next-state: lock on arbitration, release on final or forced-final beat
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n = rr_ptr;
    beat_n = beat_cnt;
    carry_n = carry_reg;
    if (state == IDLE) begin
      if (|req_valid) begin
        owner_n = found_hi ? pick_hi : pick_lo;
        state_n = LOCKED;
        beat_n = 5'd0;
      end
    end else if (accept) begin
      if (fin) begin
        state_n = IDLE;
        rr_n = (owner == IDW'(NREQ-1)) ? '0 : owner + IDW'(1);
        carry_n = 1'b0;
      end else begin
        beat_n = beat_cnt + 5'd1;
        carry_n = cout;
      end
    end
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      carry_reg <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_n;
      beat_cnt <= beat_n;
      carry_reg <= carry_n;
    end
  end
  // result register: load on accept, hold under backpressure, clear on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_s <= '0;
      res_cout <= 1'b0;
      res_id <= '0;
      res_last <= 1'b0;
      res_trunc <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_s <= sum;
      res_cout <= cout;
      res_id <= owner;
      res_last <= fin;
      res_trunc <= at_max & ~own_last;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
  a1csah64bits #(.N(N)) adder (
    .a(op_a),
    .b(op_b),
    .cin(cin),
    .s(sum),
    .cout(cout),
    .gen(unused_gen),
    .prop(unused_prop)
  );
endmodule

// a1csah64bits: hierarchical add-one carry-select adder built from 8-bit blocks
module a1csah64bits #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gen,
  output logic         prop
);
  localparam int B = 8;
  localparam int NB = N / B;
  logic [NB:0] c;
  assign c[0] = cin;
  for (genvar k = 0; k < NB; k++) begin : blk
    logic [B:0] s0, s1;
    assign s0 = {1'b0, a[k*B +: B]} + {1'b0, b[k*B +: B]};
    assign s1 = s0 + {{B{1'b0}}, 1'b1};
    assign s[k*B +: B] = c[k] ? s1[B-1:0] : s0[B-1:0];
    assign c[k+1] = c[k] ? s1[B] : s0[B];
  end
  assign cout = c[NB];
  assign prop = &(a ^ b);
  assign gen = prop ? 1'b0 : cout;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed and randomized scoreboard bench for adder_share_arb
module tb_adder_share_arb;
  localparam int N = 64, NREQ = 2, MAXBEATS = 4, IDW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready, req_cin = '0, req_last = '0;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0;
  logic res_valid, res_ready = 1'b0, res_cout, res_last, res_trunc;
  logic [N-1:0] res_s;
  logic [IDW-1:0] res_id;

  adder_share_arb #(.N(N), .NREQ(NREQ), .MAXBEATS(MAXBEATS), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_cout(res_cout),
    .res_id(res_id), .res_last(res_last), .res_trunc(res_trunc)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [N-1:0] a; logic [N-1:0] b; logic cin; logic last;} beat_t;
  typedef struct packed {logic [N-1:0] s; logic cout; logic last; logic trunc;} exp_t;
  typedef struct {int id; logic [N-1:0] s; logic cout; logic last; logic trunc; int cyc;} log_t;

  beat_t sq[NREQ][$];
  exp_t eq[NREQ][$];
  int acc[NREQ][$];
  log_t rlog[$];
  int pos[NREQ];
  logic pcarry[NREQ];
  int tests = 0, fails = 0, cyc = 0, pv = 100, pr = 100, hold = 0, c0 = 0;
  bit bp_arm = 0, post_rst = 0, prev_stall = 0;
  logic [N-1:0] p_s;
  logic [IDW-1:0] p_id;
  logic [2:0] p_flags;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: each requester's beats form transactions of at most MAXBEATS words;
  // the words are a multi-word addition with carry rippling from word to word.
  task automatic push(int i, logic [N-1:0] a, logic [N-1:0] b, logic cin, logic last);
    beat_t bt;
    exp_t e;
    logic [N:0] full;
    logic c;
    bt.a = a; bt.b = b; bt.cin = cin; bt.last = last;
    sq[i].push_back(bt);
    c = (pos[i] == 0) ? cin : pcarry[i];
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    e.s = full[N-1:0];
    e.cout = full[N];
    e.last = last || (pos[i] == MAXBEATS - 1);
    e.trunc = !last && (pos[i] == MAXBEATS - 1);
    eq[i].push_back(e);
    pos[i] = e.last ? 0 : pos[i] + 1;
    pcarry[i] = e.last ? 1'b0 : e.cout;
  endtask

  task automatic clear_logs();
    rlog.delete();
    for (int i = 0; i < NREQ; i++) acc[i].delete();
  endtask

  task automatic clear_all();
    clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      sq[i].delete();
      eq[i].delete();
      pos[i] = 0;
      pcarry[i] = 1'b0;
    end
    prev_stall = 0;
    hold = 0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += sq[i].size() + eq[i].size();
    return n;
  endfunction

  task automatic drive();
    bit on;
    for (int i = 0; i < NREQ; i++) begin
      on = (sq[i].size() > 0) && (int'($urandom_range(99)) < pv);
      req_valid[i] = on;
      if (sq[i].size() > 0) begin
        req_a[i*N +: N] = sq[i][0].a;
        req_b[i*N +: N] = sq[i][0].b;
        req_cin[i] = sq[i][0].cin;
        req_last[i] = sq[i][0].last;
      end else begin
        req_a[i*N +: N] = {$urandom, $urandom};
        req_b[i*N +: N] = {$urandom, $urandom};
        req_cin[i] = 1'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    res_ready = (hold > 0) ? 1'b0 : (int'($urandom_range(99)) < pr);
    if (hold > 0) hold--;
  endtask

  // One cycle: sample just before the rising edge, compare, retire handshakes, then drive.
  task automatic step();
    exp_t e;
    log_t l;
    int id;
    #4;
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end else begin
      if (post_rst) begin
        chk("post_rst_res_valid", 64'(res_valid), 64'd0);
        chk("post_rst_req_ready", 64'(req_ready), 64'd0);
        post_rst = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(res_valid), 64'd1);
        chk("stall_s", res_s, p_s);
        chk("stall_id", 64'(res_id), 64'(p_id));
        chk("stall_flags", 64'({res_cout, res_last, res_trunc}), 64'(p_flags));
      end
      if (res_valid && !res_ready) chk("stall_req_ready", 64'(req_ready), 64'd0);
      if ($countones(req_ready) > 1) chk("req_ready_onehot", 64'(req_ready), 64'd0);
      if (res_valid && res_ready) begin
        id = int'(res_id);
        if (id >= NREQ || eq[id].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL res_unexpected id=%0d s=%h (cycle %0d)", id, res_s, cyc);
        end else begin
          e = eq[id].pop_front();
          chk("res_s", res_s, e.s);
          chk("res_cout", 64'(res_cout), 64'(e.cout));
          chk("res_last", 64'(res_last), 64'(e.last));
          chk("res_trunc", 64'(res_trunc), 64'(e.trunc));
        end
        l.id = id; l.s = res_s; l.cout = res_cout; l.last = res_last; l.trunc = res_trunc; l.cyc = cyc;
        rlog.push_back(l);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i] && sq[i].size() > 0) begin
          void'(sq[i].pop_front());
          acc[i].push_back(cyc);
        end
      prev_stall = res_valid && !res_ready;
      p_s = res_s;
      p_id = res_id;
      p_flags = {res_cout, res_last, res_trunc};
      if (bp_arm && rlog.size() == 1) begin
        hold = 3;
        bp_arm = 0;
      end
    end
    cyc++;
    @(negedge clk);
    drive();
  endtask

  task automatic run(int maxc);
    int n = 0;
    while ((pending() > 0) && n < maxc) begin
      step();
      n++;
    end
    for (int k = 0; k < 3; k++) step();
    chk("drain_pending", 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    drive();
    step();
    rst = 1'b0;
    post_rst = 1;
    c0 = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_all();
    @(negedge clk);
    drive();
    do_reset();

    // single-beat add with carry out
    push(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    drive();
    c0 = cyc;
    run(20);
    chk("t1_count", 64'(rlog.size()), 64'd1);
    chk("t1_accept_lat", 64'(acc[0][0] - c0), 64'd1);
    chk("t1_result_lat", 64'(rlog[0].cyc - c0), 64'd2);
    chk("t1_s", rlog[0].s, 64'd0);
    chk("t1_cout", 64'(rlog[0].cout), 64'd1);
    chk("t1_id", 64'(rlog[0].id), 64'd0);
    chk("t1_last_trunc", 64'({rlog[0].last, rlog[0].trunc}), 64'b10);

    // carry chained across two beats
    clear_logs();
    push(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    push(1, 64'd5, 64'd7, 1'b0, 1'b1);
    drive();
    run(20);
    chk("t2_count", 64'(rlog.size()), 64'd2);
    chk("t2_b0_s", rlog[0].s, 64'd0);
    chk("t2_b0_cout", 64'(rlog[0].cout), 64'd1);
    chk("t2_b1_s", rlog[1].s, 64'd13);
    chk("t2_b1_cout_last", 64'({rlog[1].cout, rlog[1].last}), 64'b01);
    chk("t2_id", 64'(rlog[1].id), 64'd1);

    // round robin with both requesters busy from reset
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
    drive();
    c0 = cyc;
    run(40);
    chk("t3_count", 64'(rlog.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("t3_rr_id", 64'(rlog[k].id), 64'(k % 2));
    chk("t3_gap_a", 64'(acc[1][0] - acc[0][0]), 64'd2);
    chk("t3_gap_b", 64'(acc[0][1] - acc[1][0]), 64'd2);

    // backpressure mid-transaction
    clear_logs();
    bp_arm = 1;
    for (int k = 0; k < 3; k++) push(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, k == 2);
    drive();
    run(40);
    chk("t4_count", 64'(rlog.size()), 64'd3);
    chk("t4_stall_gap", 64'(rlog[1].cyc - rlog[0].cyc), 64'd4);

    // truncation at MAXBEATS
    clear_logs();
    for (int k = 0; k < 6; k++) push(0, 64'(k), 64'd10, 1'b1, k == 5);
    drive();
    run(40);
    chk("t5_count", 64'(rlog.size()), 64'd6);
    chk("t5_b2_s_trunc", {rlog[2].s[59:0], rlog[2].trunc, rlog[2].last, 2'b00}, {60'd12, 4'b0000});
    chk("t5_b3_last_trunc", 64'({rlog[3].last, rlog[3].trunc}), 64'b11);
    chk("t5_b3_s", rlog[3].s, 64'd13);
    chk("t5_b4_s", rlog[4].s, 64'd15);
    chk("t5_b4_flags", 64'({rlog[4].last, rlog[4].trunc}), 64'b00);
    chk("t5_rearb_gap", 64'(acc[0][4] - acc[0][3]), 64'd2);

    // reset in the middle of a transaction
    clear_logs();
    for (int k = 0; k < 3; k++) push(0, 64'd100, 64'd200, 1'b0, k == 2);
    drive();
    for (int n = 0; n < 20 && acc[0].size() < 2; n++) step();
    chk("t6_two_accepted", 64'(acc[0].size()), 64'd2);
    do_reset();
    push(0, 64'd3, 64'd4, 1'b1, 1'b1);
    push(1, 64'd10, 64'd20, 1'b0, 1'b1);
    drive();
    run(30);
    chk("t6_count", 64'(rlog.size()), 64'd2);
    chk("t6_first_id", 64'(rlog[0].id), 64'd0);
    chk("t6_first_s", rlog[0].s, 64'd8);
    chk("t6_second_s", rlog[1].s, 64'd30);

    // randomized traffic with random valid gaps and backpressure
    do_reset();
    pv = 70;
    pr = 70;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (sq[i].size() < 8 && $urandom_range(9) == 0) begin
          int len;
          len = int'($urandom_range(6, 1));
          for (int k = 0; k < len; k++)
            push(i, ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
                 ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom}, 1'($urandom), k == len - 1);
        end
      step();
    end
    pv = 100;
    pr = 100;
    run(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
